// File: rtl/tcp_tx_arbiter_if.sv
// Bundle of the per-engine tx request side and the single TCP tx send side.
// Latency: none; this is wiring only.
// Backpressure: carries valid/ready pairs; the arbiter owns the ready returned to each engine.
interface tcp_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int META_W  = 48,
  parameter int DATA_W  = 512
);
  // Engine-facing side, requester i occupies slice i.
  logic [NUM_REQ-1:0]            s_meta_valid;
  logic [NUM_REQ*META_W-1:0]     s_meta_data;
  logic [NUM_REQ-1:0]            s_meta_ready;
  logic [NUM_REQ-1:0]            s_data_valid;
  logic [NUM_REQ*DATA_W-1:0]     s_data_data;
  logic [NUM_REQ*DATA_W/8-1:0]   s_data_keep;
  logic [NUM_REQ-1:0]            s_data_last;
  logic [NUM_REQ-1:0]            s_data_ready;

  // TCP stack send side.
  logic                          m_meta_valid;
  logic [META_W-1:0]             m_meta_data;
  logic                          m_meta_ready;
  logic                          m_data_valid;
  logic [DATA_W-1:0]             m_data_data;
  logic [DATA_W/8-1:0]           m_data_keep;
  logic                          m_data_last;
  logic                          m_data_ready;

  // Arbiter view: consumes engine requests, drives the TCP send side.
  modport master (
    input  s_meta_valid, s_meta_data, s_data_valid, s_data_data, s_data_keep, s_data_last,
    input  m_meta_ready, m_data_ready,
    output s_meta_ready, s_data_ready,
    output m_meta_valid, m_meta_data, m_data_valid, m_data_data, m_data_keep, m_data_last
  );

  // Environment view: engines plus TCP stack.
  modport slave (
    output s_meta_valid, s_meta_data, s_data_valid, s_data_data, s_data_keep, s_data_last,
    output m_meta_ready, m_data_ready,
    input  s_meta_ready, s_data_ready,
    input  m_meta_valid, m_meta_data, m_data_valid, m_data_data, m_data_keep, m_data_last
  );
endinterface

// File: rtl/tcp_tx_arbiter.sv
// Packet-atomic round-robin share of one TCP tx meta+data path among NUM_REQ engines.
// Latency: meta valid 1 cycle after request (registered IDLE pick); meta/data then pass combinationally.
// Backpressure: m_*_ready is steered only to the granted engine; all others see ready=0.
// Optional TX_ARB_STATS_EN: adds pkt_cnt (per-requester packets) and stall_cnt (saturating stall cycles).
module tcp_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int META_W  = 48,
  parameter int DATA_W  = 512
) (
  input  logic             clk,
  input  logic             rst,
  tcp_tx_arbiter_if.master bus,
  output logic [2:0]       grant_idx,
  output logic             busy
`ifdef TX_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0] pkt_cnt,
  output logic [31:0]           stall_cnt
`endif
);
  localparam int KEEP_W = DATA_W / 8;

  typedef enum logic [1:0] {ST_IDLE, ST_META, ST_DATA} state_t;

  state_t       r_state;
  logic [2:0]   r_grant;
  logic [2:0]   r_last_grant;
  logic         r_busy;

  logic               w_any;
  logic [2:0]         w_winner;
  logic               w_sel_meta_vld;
  logic [META_W-1:0]  w_sel_meta_dat;
  logic               w_sel_data_vld;
  logic [DATA_W-1:0]  w_sel_data_dat;
  logic [KEEP_W-1:0]  w_sel_data_keep;
  logic               w_sel_data_last;
  logic [NUM_REQ-1:0] w_grant_oh;
  logic               w_meta_hs;
  logic               w_data_done;

  // Round-robin pick: first requesting index after the last finished grant, wrapping.
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_any && bus.s_meta_valid[i] && (i == (int'(r_last_grant) + k) % NUM_REQ)) begin
          w_any    = 1'b1;
          w_winner = 3'(i);
        end
      end
    end
  end

  // Select the granted requester's slices and build its one-hot ready mask.
  always_comb begin
    w_sel_meta_vld  = 1'b0;
    w_sel_meta_dat  = '0;
    w_sel_data_vld  = 1'b0;
    w_sel_data_dat  = '0;
    w_sel_data_keep = '0;
    w_sel_data_last = 1'b0;
    w_grant_oh      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant == 3'(i)) begin
        w_sel_meta_vld  = bus.s_meta_valid[i];
        w_sel_meta_dat  = bus.s_meta_data[i*META_W +: META_W];
        w_sel_data_vld  = bus.s_data_valid[i];
        w_sel_data_dat  = bus.s_data_data[i*DATA_W +: DATA_W];
        w_sel_data_keep = bus.s_data_keep[i*KEEP_W +: KEEP_W];
        w_sel_data_last = bus.s_data_last[i];
        w_grant_oh[i]   = 1'b1;
      end
    end
  end

  // Drive the send side and return ready; nothing is valid while IDLE.
  always_comb begin
    bus.m_meta_valid = (r_state == ST_META) && w_sel_meta_vld;
    bus.m_meta_data  = w_sel_meta_dat;
    bus.s_meta_ready = ((r_state == ST_META) && bus.m_meta_ready) ? w_grant_oh : '0;
    bus.m_data_valid = (r_state == ST_DATA) && w_sel_data_vld;
    bus.m_data_data  = w_sel_data_dat;
    bus.m_data_keep  = w_sel_data_keep;
    bus.m_data_last  = (r_state == ST_DATA) && w_sel_data_last;
    bus.s_data_ready = ((r_state == ST_DATA) && bus.m_data_ready) ? w_grant_oh : '0;
  end

  assign w_meta_hs   = bus.m_meta_valid && bus.m_meta_ready;
  assign w_data_done = bus.m_data_valid && bus.m_data_ready && bus.m_data_last;

  // Packet FSM: arbitrate in IDLE, hold the grant through meta and data until the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= 3'(NUM_REQ - 1);
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant <= w_winner;
            r_state <= ST_META;
            r_busy  <= 1'b1;
          end
        end
        ST_META: begin
          if (w_meta_hs) begin
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_data_done) begin
            r_last_grant <= r_grant;
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign grant_idx = r_grant;
  assign busy      = r_busy;

`ifdef TX_ARB_STATS_EN
  logic [NUM_REQ*32-1:0] r_pkt_cnt;
  logic [31:0]           r_stall_cnt;
  logic                  w_stall;

  assign w_stall = (bus.m_meta_valid && !bus.m_meta_ready) || (bus.m_data_valid && !bus.m_data_ready);

  // Per-requester completed packets (wrapping) and send-side stall cycles (saturating).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pkt_cnt   <= '0;
      r_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_data_done && (r_grant == 3'(i))) begin
          r_pkt_cnt[i*32 +: 32] <= r_pkt_cnt[i*32 +: 32] + 32'd1;
        end
      end
      if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign pkt_cnt   = r_pkt_cnt;
  assign stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_tcp_tx_arbiter.sv
// Bench for tcp_tx_arbiter: arbitration table, directed corner sequences, randomized traffic
// against a transaction-level round-robin model.
`timescale 1ns/1ps
module tb_tcp_tx_arbiter;
  localparam int NR = 4;
  localparam int MW = 48;
  localparam int DW = 512;
  localparam int KW = DW / 8;

  logic clk = 1'b0;
  logic rst;
  logic [2:0] grant_idx;
  logic busy;
`ifdef TX_ARB_STATS_EN
  logic [NR*32-1:0] pkt_cnt;
  logic [31:0]      stall_cnt;
`endif

  always #5 clk = ~clk;

  tcp_tx_arbiter_if #(.NUM_REQ(NR), .META_W(MW), .DATA_W(DW)) bus();

  tcp_tx_arbiter #(.NUM_REQ(NR), .META_W(MW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .grant_idx (grant_idx),
    .busy      (busy)
`ifdef TX_ARB_STATS_EN
    ,
    .pkt_cnt   (pkt_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [DW-1:0] mk_dat(input logic [31:0] s, input int b);
    logic [DW-1:0] d;
    for (int w = 0; w < DW/32; w++) d[w*32 +: 32] = s + 32'(b) * 32'h1000 + 32'(w);
    return d;
  endfunction

  function automatic logic [KW-1:0] mk_keep(input logic [31:0] s, input bit lst);
    logic [KW-1:0] k;
    k = '1;
    if (lst) k = k >> s[5:0];
    return k;
  endfunction

  function automatic logic [MW-1:0] meta_of(input int i, input int tag);
    return {32'h40 + 32'(i*64), 16'h0005 + 16'(tag*16 + i)};
  endfunction

  task automatic clear_inputs();
    bus.s_meta_valid = '0;
    bus.s_meta_data  = '0;
    bus.s_data_valid = '0;
    bus.s_data_data  = '0;
    bus.s_data_keep  = '0;
    bus.s_data_last  = '0;
    bus.m_meta_ready = 1'b0;
    bus.m_data_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One packet from requester r with optional meta stall and toggling data ready.
  task automatic send_pkt(input int r, input int nb, input int mstall, input bit tog);
    logic [31:0] sd;
    logic [DW-1:0] ed;
    int b;
    int cyc;
    bit rdy;
    sd = $urandom;
    clear_inputs();
    bus.s_meta_valid[r] = 1'b1;
    bus.s_meta_data[r*MW +: MW] = meta_of(r, 7);
    bus.m_meta_ready = (mstall == 0);
    bus.m_data_ready = 1'b1;
    #1;
    chk("pkt_idle_no_mvld", 64'(bus.m_meta_valid), 64'd0);
    @(posedge clk); #1;
    chk("pkt_grant", 64'(grant_idx), 64'(r));
    chk("pkt_busy", 64'(busy), 64'd1);
    for (int k = 0; k < mstall; k++) begin
      chk("pkt_meta_hold_vld", 64'(bus.m_meta_valid), 64'd1);
      chk("pkt_meta_hold_dat", 64'(bus.m_meta_data), 64'(meta_of(r, 7)));
      chk("pkt_meta_stall_rdy", 64'(bus.s_meta_ready), 64'd0);
      @(posedge clk); #1;
    end
    bus.m_meta_ready = 1'b1;
    #1;
    chk("pkt_meta_rdy", 64'(bus.s_meta_ready), 64'(1) << r);
    @(posedge clk); #1;
    bus.s_meta_valid = '0;
    b = 0;
    cyc = 0;
    while (b < nb && cyc < 64) begin
      rdy = tog ? (cyc % 2 == 1) : 1'b1;
      ed = mk_dat(sd, b);
      bus.s_data_valid[r] = 1'b1;
      bus.s_data_data[r*DW +: DW] = ed;
      bus.s_data_last[r] = (b == nb - 1);
      bus.s_data_keep[r*KW +: KW] = '1;
      bus.m_data_ready = rdy;
      #1;
      chk("pkt_data_vld", 64'(bus.m_data_valid), 64'd1);
      chk("pkt_sdata_rdy", 64'(bus.s_data_ready), rdy ? (64'(1) << r) : 64'd0);
      chk("pkt_data_lo", bus.m_data_data[63:0], ed[63:0]);
      chk("pkt_data_last", 64'(bus.m_data_last), 64'(b == nb - 1));
      @(posedge clk); #1;
      if (rdy) b++;
      cyc++;
    end
    chk("pkt_beats", 64'(b), 64'(nb));
    clear_inputs();
    #1;
    chk("pkt_done_busy", 64'(busy), 64'd0);
  endtask

  typedef struct { logic [MW-1:0] meta; int nb; logic [31:0] seed; } pkt_t;
  pkt_t q [NR][$];
  int order[$];

  // Drives engines from q and checks the send side against a transaction-level model:
  // each packet goes to the next pending requester after the previous packet's owner.
  task automatic run_engine(input bit rnd, input int max_cyc);
    bit inpkt[NR];
    int beat[NR];
    bit mhs[NR];
    bit dhs[NR];
    int m_last, m_cur, m_beat, cyc, exp_r, c;
    bit done, lst;
    logic [DW-1:0] ed;
    m_last = NR - 1;
    m_cur = -1;
    m_beat = 0;
    cyc = 0;
    done = 1'b0;
    order.delete();
    for (int i = 0; i < NR; i++) begin inpkt[i] = 1'b0; beat[i] = 0; end
    while (!done && cyc < max_cyc) begin
      for (int i = 0; i < NR; i++) begin
        bus.s_meta_valid[i] = (q[i].size() > 0) && !inpkt[i];
        bus.s_meta_data[i*MW +: MW] = (q[i].size() > 0) ? q[i][0].meta : '0;
        if (inpkt[i]) begin
          lst = (beat[i] == q[i][0].nb - 1);
          bus.s_data_valid[i] = rnd ? ($urandom_range(3) != 0) : 1'b1;
          bus.s_data_data[i*DW +: DW] = mk_dat(q[i][0].seed, beat[i]);
          bus.s_data_last[i] = lst;
          bus.s_data_keep[i*KW +: KW] = mk_keep(q[i][0].seed, lst);
        end else begin
          bus.s_data_valid[i] = rnd ? ($urandom_range(3) == 0) : 1'b0;
          bus.s_data_data[i*DW +: DW] = mk_dat($urandom, 0);
          bus.s_data_last[i] = $urandom_range(1) == 1;
          bus.s_data_keep[i*KW +: KW] = '1;
        end
      end
      bus.m_meta_ready = rnd ? ($urandom_range(2) != 0) : 1'b1;
      bus.m_data_ready = rnd ? ($urandom_range(2) != 0) : 1'b1;
      #4;
      chk("eng_rdy_onehot", 64'($countones({bus.s_meta_ready, bus.s_data_ready}) <= 1), 64'd1);
      for (int i = 0; i < NR; i++) begin
        mhs[i] = bus.s_meta_valid[i] && bus.s_meta_ready[i];
        dhs[i] = bus.s_data_valid[i] && bus.s_data_ready[i];
        if (dhs[i]) chk("eng_stray_data", 64'(inpkt[i]), 64'd1);
      end
      if (bus.m_meta_valid && bus.m_meta_ready) begin
        exp_r = -1;
        for (int k = 1; k <= NR; k++) begin
          c = (m_last + k) % NR;
          if (exp_r < 0 && q[c].size() > 0 && !inpkt[c]) exp_r = c;
        end
        chk("eng_no_interleave", 64'(m_cur < 0), 64'd1);
        chk("eng_grant", 64'(grant_idx), 64'(exp_r));
        if (exp_r >= 0) begin
          chk("eng_meta", 64'(bus.m_meta_data), 64'(q[exp_r][0].meta));
          chk("eng_meta_rdy", 64'(bus.s_meta_ready), 64'(1) << exp_r);
          order.push_back(exp_r);
        end
        m_cur = exp_r;
        m_beat = 0;
      end
      if (bus.m_data_valid && bus.m_data_ready) begin
        chk("eng_data_owner", 64'(m_cur >= 0), 64'd1);
        if (m_cur >= 0) begin
          lst = (m_beat == q[m_cur][0].nb - 1);
          ed = mk_dat(q[m_cur][0].seed, m_beat);
          chk("eng_data_lo", bus.m_data_data[63:0], ed[63:0]);
          chk("eng_data_hi", bus.m_data_data[DW-1:DW-64], ed[DW-1:DW-64]);
          chk("eng_keep", 64'(bus.m_data_keep), 64'(mk_keep(q[m_cur][0].seed, lst)));
          chk("eng_last", 64'(bus.m_data_last), 64'(lst));
          m_beat++;
          if (lst) begin m_last = m_cur; m_cur = -1; end
        end
      end
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) begin
        if (mhs[i]) begin
          inpkt[i] = 1'b1;
          beat[i] = 0;
        end else if (dhs[i] && inpkt[i]) begin
          beat[i]++;
          if (beat[i] == q[i][0].nb) begin
            void'(q[i].pop_front());
            inpkt[i] = 1'b0;
            beat[i] = 0;
          end
        end
      end
      cyc++;
      done = (m_cur < 0);
      for (int i = 0; i < NR; i++) if (q[i].size() > 0) done = 1'b0;
    end
    chk("eng_drained", 64'(done), 64'd1);
    clear_inputs();
  endtask

  typedef struct { logic [NR-1:0] mask; int exp_g; } vec_t;
  vec_t tbl[12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] ed;
    int g;
    tbl[0]  = '{4'b1111, 0};
    tbl[1]  = '{4'b1111, 1};
    tbl[2]  = '{4'b0101, 2};
    tbl[3]  = '{4'b1010, 3};
    tbl[4]  = '{4'b1010, 1};
    tbl[5]  = '{4'b1010, 3};
    tbl[6]  = '{4'b0001, 0};
    tbl[7]  = '{4'b1000, 3};
    tbl[8]  = '{4'b0110, 1};
    tbl[9]  = '{4'b0110, 2};
    tbl[10] = '{4'b1111, 3};
    tbl[11] = '{4'b0011, 0};

    do_reset();
    bus.m_meta_ready = 1'b1;
    bus.m_data_ready = 1'b1;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant_idx), 64'd0);
    chk("rst_mmeta_vld", 64'(bus.m_meta_valid), 64'd0);
    chk("rst_mdata_vld", 64'(bus.m_data_valid), 64'd0);
    chk("rst_smeta_rdy", 64'(bus.s_meta_ready), 64'd0);
    chk("rst_sdata_rdy", 64'(bus.s_data_ready), 64'd0);
`ifdef TX_ARB_STATS_EN
    chk("rst_pkt_cnt", 64'(pkt_cnt[63:0] | pkt_cnt[127:64]), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif

    // Arbitration table: single-beat packets, readies high.
    for (int t = 0; t < 12; t++) begin
      clear_inputs();
      g = tbl[t].exp_g;
      bus.m_meta_ready = 1'b1;
      bus.m_data_ready = 1'b1;
      for (int i = 0; i < NR; i++) begin
        bus.s_meta_valid[i] = tbl[t].mask[i];
        bus.s_meta_data[i*MW +: MW] = meta_of(i, 0);
        bus.s_data_valid[i] = tbl[t].mask[i];
        bus.s_data_data[i*DW +: DW] = mk_dat(32'(i*256 + t), 0);
        bus.s_data_last[i] = 1'b1;
        bus.s_data_keep[i*KW +: KW] = '1;
      end
      #1;
      chk("tbl_idle_mvld", 64'(bus.m_meta_valid), 64'd0);
      chk("tbl_idle_sdrdy", 64'(bus.s_data_ready), 64'd0);
      @(posedge clk); #1;
      chk("tbl_grant", 64'(grant_idx), 64'(g));
      chk("tbl_busy", 64'(busy), 64'd1);
      chk("tbl_mvld", 64'(bus.m_meta_valid), 64'd1);
      chk("tbl_mdat", 64'(bus.m_meta_data), 64'(meta_of(g, 0)));
      chk("tbl_smrdy", 64'(bus.s_meta_ready), 64'(1) << g);
      @(posedge clk); #1;
      bus.s_meta_valid = '0;
      #1;
      ed = mk_dat(32'(g*256 + t), 0);
      chk("tbl_dvld", 64'(bus.m_data_valid), 64'd1);
      chk("tbl_ddat", bus.m_data_data[63:0], ed[63:0]);
      chk("tbl_dlast", 64'(bus.m_data_last), 64'd1);
      chk("tbl_sdrdy", 64'(bus.s_data_ready), 64'(1) << g);
      chk("tbl_data_mvld", 64'(bus.m_meta_valid), 64'd0);
      @(posedge clk); #1;
      chk("tbl_end_busy", 64'(busy), 64'd0);
      chk("tbl_end_grant", 64'(grant_idx), 64'(g));
    end

    // Backpressure: meta stalled 5 cycles, data ready toggling.
    send_pkt(1, 3, 5, 1'b1);

    // Reset in DATA after 2 of 4 beats.
    clear_inputs();
    bus.m_meta_ready = 1'b1;
    bus.m_data_ready = 1'b1;
    bus.s_meta_valid[0] = 1'b1;
    bus.s_meta_data[MW-1:0] = meta_of(0, 3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.s_meta_valid = '0;
    for (int b = 0; b < 2; b++) begin
      ed = mk_dat(32'h5A00, b);
      bus.s_data_valid[0] = 1'b1;
      bus.s_data_data[DW-1:0] = ed;
      bus.s_data_keep[KW-1:0] = '1;
      #1;
      chk("rstd_beat", bus.m_data_data[63:0], ed[63:0]);
      @(posedge clk); #1;
    end
    bus.s_data_data[DW-1:0] = mk_dat(32'h5A00, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstd_mdata_vld", 64'(bus.m_data_valid), 64'd0);
    chk("rstd_sdata_rdy", 64'(bus.s_data_ready), 64'd0);
    chk("rstd_busy", 64'(busy), 64'd0);
    chk("rstd_grant", 64'(grant_idx), 64'd0);
    chk("rstd_mmeta_vld", 64'(bus.m_meta_valid), 64'd0);
    @(posedge clk); #1;
    chk("rstd_data_only_busy", 64'(busy), 64'd0);
    chk("rstd_data_only_vld", 64'(bus.m_data_valid), 64'd0);
    send_pkt(0, 1, 0, 1'b0);

`ifdef TX_ARB_STATS_EN
    do_reset();
    send_pkt(2, 1, 0, 1'b0);
    send_pkt(2, 2, 0, 1'b0);
    send_pkt(2, 3, 0, 1'b0);
    send_pkt(0, 2, 0, 1'b0);
    chk("stat_pkt2", 64'(pkt_cnt[95:64]), 64'd3);
    chk("stat_pkt0", 64'(pkt_cnt[31:0]), 64'd1);
    chk("stat_pkt1", 64'(pkt_cnt[63:32]), 64'd0);
    chk("stat_stall0", 64'(stall_cnt), 64'd0);
    send_pkt(3, 1, 5, 1'b0);
    chk("stat_stall5", 64'(stall_cnt), 64'd5);
    chk("stat_pkt3", 64'(pkt_cnt[127:96]), 64'd1);
`endif

    // All requesters busy with 2-beat packets, readies always high.
    do_reset();
    for (int i = 0; i < NR; i++)
      for (int p = 0; p < 2; p++) q[i].push_back('{meta_of(i, p + 1), 2, $urandom});
    run_engine(1'b0, 500);
    chk("rr_order_len", 64'(order.size()), 64'd8);
    for (int j = 0; j < order.size() && j < 8; j++) chk("rr_order", 64'(order[j]), 64'(j % NR));

    // Randomized traffic, gaps and backpressure.
    for (int round = 0; round < 3; round++) begin
      do_reset();
      for (int i = 0; i < NR; i++) begin
        int np;
        np = $urandom_range(5);
        for (int p = 0; p < np; p++)
          q[i].push_back('{meta_of(i, p + 4), $urandom_range(4, 1), $urandom});
      end
      run_engine(1'b1, 5000);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/tcp_tx_arbiter.md
Name: tcp_tx_arbiter

Overview:
- Shares the single TCP send path (tx metadata + 512-bit tx data) between NUM_REQ local engines, e.g. barrier and collective engines.
- Arbitration is packet-atomic round-robin: one metadata beat, then that requester's data beats until last.
- Sits between the engines and the TCP stack's send interface.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- META_W, 48, metadata width: {length[47:16], session[15:0]}.
- DATA_W, 512, tx data width; keep width is DATA_W/8.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- s_meta_valid  in  NUM_REQ  per-requester metadata valid.
- s_meta_data  in  NUM_REQ*META_W  per-requester metadata; requester i at slice i.
- s_meta_ready  out  NUM_REQ  per-requester metadata ready.
- s_data_valid  in  NUM_REQ  per-requester data valid.
- s_data_data  in  NUM_REQ*DATA_W  per-requester data.
- s_data_keep  in  NUM_REQ*DATA_W/8  per-requester keep.
- s_data_last  in  NUM_REQ  per-requester last.
- s_data_ready  out  NUM_REQ  per-requester data ready.
- m_meta_valid / m_meta_data / m_meta_ready  out/out/in  1/META_W/1  to TCP tx metadata.
- m_data_valid / m_data_data / m_data_keep / m_data_last / m_data_ready  out/out/out/out/in  1/DATA_W/DATA_W/8/1/1  to TCP tx data.
- grant_idx  out  3  index of the current or last granted requester.
- busy  out  1  high in META or DATA.

Behaviour:
- State machine: IDLE -> META -> DATA -> IDLE.
- Reset: state=IDLE; last_grant=NUM_REQ-1, so requester 0 wins first; grant_idx=0; all ready outputs, m_meta_valid, m_data_valid and busy are 0.
- Reset applied mid-packet: same reset values on the next edge. A partially forwarded packet is abandoned; no further beats are forwarded.

IDLE:
- If any s_meta_valid is set, pick the first set bit scanning (last_grant+1) mod NUM_REQ upward with wrap.
- Register the winner into grant_idx and move to META.
- No output valid is asserted in IDLE, so m_meta_valid rises 1 cycle after the request is seen.
- s_data_valid without a metadata request never wins arbitration.

META:
- m_meta_valid = s_meta_valid[grant_idx]; m_meta_data = slice grant_idx.
- s_meta_ready[grant_idx] = m_meta_ready; all other ready bits are 0.
- On m_meta_valid & m_meta_ready, go to DATA.
- If the granted requester drops meta_valid before the handshake, stay in META. Requesters must hold valid until the handshake.

DATA:
- m_data_* is a combinational mux of the grant_idx slices.
- s_data_ready[grant_idx] = m_data_ready; all other ready bits are 0.
- On a valid & ready & last beat: last_grant <= grant_idx, go to IDLE.
- A beat with last=1 on the first data beat is legal (single-beat packet).

Fairness and throughput:
- Each packet costs 1 IDLE cycle of overhead.
- A requester that just finished has lowest priority in the next arbitration. With all requesters asserting, grant order is 0,1,...,NUM_REQ-1,0,...
- Simultaneous events: new requests arriving during META/DATA are ignored until IDLE. A request arriving on the same cycle as the last beat is seen in the following IDLE cycle.

Other rules:
- No combinational path from s_meta_valid to m_meta_valid in IDLE.
- In META and DATA, valid/ready paths are combinational through the mux.
- Metadata is forwarded unmodified; the length field is not checked against the data beats.
- busy = (state != IDLE).

Optional Feature:
- Macro: TX_ARB_STATS_EN.
- With the macro defined, add output port pkt_cnt (NUM_REQ*32).
  - Counter i increments by 1 on each completed last-beat handshake of requester i.
  - Counters wrap from 0xFFFFFFFF to 0.
  - Counters clear on rst.
- Add output port stall_cnt (32): increments every cycle in which m_meta_valid|m_data_valid is 1 and the matching ready is 0. Saturates at 0xFFFFFFFF; clears on rst.
- Without the macro: neither port nor any counter logic exists.

Test Plan:
- Single requester: req0 sends meta {len=0x40, sess=0x0005}, 1 data beat with last=1, all readies 1 -> m_meta_valid rises 1 cycle after the request, m_meta_data=0x000000400005, data forwarded the cycle after the meta handshake, busy falls after last, grant_idx=0.
- All 4 requesters request continuously with 2-beat packets -> grant order 0,1,2,3,0,1; no interleaving of beats across requesters; exactly one s_data_ready bit high at a time.
- Backpressure: m_meta_ready held 0 for 5 cycles, then m_data_ready toggling every cycle -> meta held stable, no beat lost or duplicated, s_data_ready mirrors m_data_ready only for the granted index.
- Wrap-around: last_grant=3, requests on 1 and 3 -> 1 wins; next arbitration 3 wins.
- Reset during DATA after 2 of 4 beats -> next cycle all valids/readies 0, state IDLE; a subsequent request from req0 is granted normally.
- With TX_ARB_STATS_EN: 3 packets from req2 and 1 from req0 -> pkt_cnt[2]=3, pkt_cnt[0]=1; 5 stalled meta cycles -> stall_cnt=5.
